trap_sequencer: RTL and testbench

- Sits between the pipeline's trap/return signalling and the single-port machine CSR file.
- Sequences the multi-register updates needed for trap entry (mepc, mcause, mtval, mstatus, mtvec lookup) and for mret (mstatus, mepc lookup). It then issues a one-cycle PC redirect.
- When idle, it passes the pipeline's own Zicsr CSR accesses straight through to the CSR file. This keeps the CSR file at one read/write port.

---
 rtl/trap_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Sequences the machine-mode CSR updates for trap entry
//               (mepc, mcause, mtval, mstatus, then mtvec lookup) and for
//               mret (mstatus, then mepc lookup), one CSR access per cycle,
//               and finishes with a one-cycle PC redirect pulse. While idle,
//               the pipeline's own Zicsr accesses pass straight through, so
//               the CSR file needs only one read/write port.
//
// Ports:
//   ctrl_clk, ctrl_reset_n           clock, asynchronous active-low reset
//   trap_valid/cause/epc/tval        trap entry request (sampled in IDLE)
//   mret_valid                       mret request (sampled in IDLE)
//   busy                             high whenever a sequence is running
//   redirect_valid, redirect_pc      one-cycle fetch redirect
//   pl_addr/pl_wdata/pl_wen/pl_rdata pipeline CSR access port
//   csr_addr/csr_wdata/csr_wen       single CSR file port (comb. read)
//   csr_rdata
//
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer #(
    parameter int VECTORED_EN = 1
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic [11:0] pl_addr,
    input  logic [31:0] pl_wdata,
    input  logic        pl_wen,
    output logic [31:0] pl_rdata,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_wen,
    input  logic [31:0] csr_rdata
);

    localparam logic [11:0] C_MSTATUS = 12'h300;
    localparam logic [11:0] C_MTVEC   = 12'h305;
    localparam logic [11:0] C_MEPC    = 12'h341;
    localparam logic [11:0] C_MCAUSE  = 12'h342;
    localparam logic [11:0] C_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_T_EPC    = 3'd1,
        S_T_CAUSE  = 3'd2,
        S_T_TVAL   = 3'd3,
        S_T_STATUS = 3'd4,
        S_T_VEC    = 3'd5,
        S_M_STATUS = 3'd6,
        S_M_EPC    = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_trap_status;
    logic [31:0] w_mret_status;
    logic [31:0] w_base;
    logic        w_vec_mode;
    logic [31:0] w_trap_pc;
    logic        w_unused_epc;

    // mepc is always written word aligned, so the low epc bits are dropped.
    assign w_unused_epc = &{1'b0, r_epc[1:0]};

    assign busy           = (r_state != S_IDLE);
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign pl_rdata       = csr_rdata;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    always_comb begin
        w_trap_status        = csr_rdata;
        w_trap_status[7]     = csr_rdata[3];
        w_trap_status[3]     = 1'b0;
        w_trap_status[12:11] = 2'b11;
    end

    // mret: MIE <= MPIE, MPIE <= 1, MPP stays M (M-only hart).
    always_comb begin
        w_mret_status        = csr_rdata;
        w_mret_status[3]     = csr_rdata[7];
        w_mret_status[7]     = 1'b1;
        w_mret_status[12:11] = 2'b11;
    end

    // mtvec is on the read port during T_VEC.
    assign w_base = {csr_rdata[31:2], 2'b00};

    generate
        if (VECTORED_EN != 0) begin : g_vectored
            assign w_vec_mode = (csr_rdata[1:0] == 2'b01) & r_cause[31];
        end else begin : g_direct
            assign w_vec_mode = 1'b0;
        end
    endgenerate

    // 4*cause[30:0] modulo 2^32 only keeps cause[29:0].
    assign w_trap_pc = w_vec_mode ? (w_base + {r_cause[29:0], 2'b00}) : w_base;

    always_comb begin
        w_state_nxt = r_state;
        csr_addr    = pl_addr;
        csr_wdata   = pl_wdata;
        csr_wen     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A trapping or returning instruction must not also write.
                csr_wen = pl_wen & ~trap_valid & ~mret_valid;
                if (trap_valid) begin
                    w_state_nxt = S_T_EPC;
                end else if (mret_valid) begin
                    w_state_nxt = S_M_STATUS;
                end
            end
            S_T_EPC: begin
                csr_addr    = C_MEPC;
                csr_wdata   = {r_epc[31:2], 2'b00};
                csr_wen     = 1'b1;
                w_state_nxt = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_addr    = C_MCAUSE;
                csr_wdata   = r_cause;
                csr_wen     = 1'b1;
                w_state_nxt = S_T_TVAL;
            end
            S_T_TVAL: begin
                csr_addr    = C_MTVAL;
                csr_wdata   = r_tval;
                csr_wen     = 1'b1;
                w_state_nxt = S_T_STATUS;
            end
            S_T_STATUS: begin
                csr_addr    = C_MSTATUS;
                csr_wdata   = w_trap_status;
                csr_wen     = 1'b1;
                w_state_nxt = S_T_VEC;
            end
            S_T_VEC: begin
                csr_addr    = C_MTVEC;
                w_state_nxt = S_IDLE;
            end
            S_M_STATUS: begin
                csr_addr    = C_MSTATUS;
                csr_wdata   = w_mret_status;
                csr_wen     = 1'b1;
                w_state_nxt = S_M_EPC;
            end
            S_M_EPC: begin
                csr_addr    = C_MEPC;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state          <= S_IDLE;
            r_cause          <= 32'd0;
            r_epc            <= 32'd0;
            r_tval           <= 32'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_redirect_valid <= 1'b0;
            if ((r_state == S_IDLE) && trap_valid) begin
                r_cause <= trap_cause;
                r_epc   <= trap_epc;
                r_tval  <= trap_tval;
            end
            if (r_state == S_T_VEC) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= w_trap_pc;
            end
            if (r_state == S_M_EPC) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= {csr_rdata[31:2], 2'b00};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Self-checking bench for trap_sequencer. Two instances
//               (vectored mode on and off) share stimulus; each owns a CSR
//               file. A transaction-level model turns each accepted request
//               into a list of expected CSR accesses plus a redirect, and a
//               compare process checks every cycle against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

    logic        clk;
    logic        rst_n;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic [11:0] pl_addr;
    logic [31:0] pl_wdata;
    logic        pl_wen;

    logic        busy1, rv1, wen1, busy0, rv0, wen0;
    logic [31:0] rpc1, rpc0, plr1, plr0, wd1, wd0, rd1, rd0;
    logic [11:0] ad1, ad0;

    logic [31:0] mem1 [0:4095];
    logic [31:0] mem0 [0:4095];
    logic [31:0] model_csr [0:4095];

    int n_chk = 0;
    int n_err = 0;

    trap_sequencer #(.VECTORED_EN(1)) dut1 (
        .ctrl_clk(clk), .ctrl_reset_n(rst_n),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_epc(trap_epc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .busy(busy1),
        .redirect_valid(rv1), .redirect_pc(rpc1),
        .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_wen(pl_wen),
        .pl_rdata(plr1), .csr_addr(ad1), .csr_wdata(wd1),
        .csr_wen(wen1), .csr_rdata(rd1)
    );

    trap_sequencer #(.VECTORED_EN(0)) dut0 (
        .ctrl_clk(clk), .ctrl_reset_n(rst_n),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_epc(trap_epc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .busy(busy0),
        .redirect_valid(rv0), .redirect_pc(rpc0),
        .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_wen(pl_wen),
        .pl_rdata(plr0), .csr_addr(ad0), .csr_wdata(wd0),
        .csr_wen(wen0), .csr_rdata(rd0)
    );

    // CSR files: combinational read, write at posedge.
    assign rd1 = mem1[ad1];
    assign rd0 = mem0[ad0];
    always @(posedge clk) begin
        if (wen1) mem1[ad1] <= wd1;
        if (wen0) mem0[ad0] <= wd0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] rpc0;
    } step_t;

    step_t       sched[$];
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_rpc0;

    function automatic step_t mk(input logic w, input logic [11:0] a, input logic [31:0] d,
                                 input logic r, input logic [31:0] p, input logic [31:0] p0);
        step_t s;
        s.wen = w; s.addr = a; s.wdata = d; s.redir = r; s.rpc = p; s.rpc0 = p0;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        step_t       s;
        logic [31:0] st, ns, base, off, tv;
        if (!rst_n) begin
            sched.delete();
            m_rv   = 1'b0;
            m_rpc  = 32'd0;
            m_rpc0 = 32'd0;
        end else begin
            m_rv = 1'b0;
            if (sched.size() != 0) begin
                s = sched.pop_front();
                if (s.wen) model_csr[s.addr] = s.wdata;
                if (s.redir) begin
                    m_rv   = 1'b1;
                    m_rpc  = s.rpc;
                    m_rpc0 = s.rpc0;
                end
            end else if (trap_valid) begin
                st = model_csr[12'h300];
                ns = st;
                ns[7] = st[3]; ns[3] = 1'b0; ns[12:11] = 2'b11;
                tv   = model_csr[12'h305];
                base = tv & 32'hFFFF_FFFC;
                off  = {1'b0, trap_cause[30:0]};
                off  = off << 2;
                sched.push_back(mk(1'b1, 12'h341, trap_epc & 32'hFFFF_FFFC, 1'b0, 0, 0));
                sched.push_back(mk(1'b1, 12'h342, trap_cause, 1'b0, 0, 0));
                sched.push_back(mk(1'b1, 12'h343, trap_tval, 1'b0, 0, 0));
                sched.push_back(mk(1'b1, 12'h300, ns, 1'b0, 0, 0));
                sched.push_back(mk(1'b0, 12'h305, 0, 1'b1,
                    ((tv[1:0] == 2'b01) && trap_cause[31]) ? base + off : base, base));
            end else if (mret_valid) begin
                st = model_csr[12'h300];
                ns = st;
                ns[3] = st[7]; ns[7] = 1'b1; ns[12:11] = 2'b11;
                sched.push_back(mk(1'b1, 12'h300, ns, 1'b0, 0, 0));
                sched.push_back(mk(1'b0, 12'h341, 0, 1'b1,
                    model_csr[12'h341] & 32'hFFFF_FFFC, model_csr[12'h341] & 32'hFFFF_FFFC));
            end else if (pl_wen) begin
                model_csr[pl_addr] = pl_wdata;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : p_cmp
        logic        e_busy, e_wen;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        if (sched.size() == 0) begin
            e_busy  = 1'b0;
            e_wen   = pl_wen & ~trap_valid & ~mret_valid;
            e_addr  = pl_addr;
            e_wdata = pl_wdata;
        end else begin
            e_busy  = 1'b1;
            e_wen   = sched[0].wen;
            e_addr  = sched[0].addr;
            e_wdata = sched[0].wdata;
        end
        chk("busy1", {31'd0, busy1}, {31'd0, e_busy});
        chk("busy0", {31'd0, busy0}, {31'd0, e_busy});
        chk("csr_wen1", {31'd0, wen1}, {31'd0, e_wen});
        chk("csr_wen0", {31'd0, wen0}, {31'd0, e_wen});
        chk("csr_addr1", {20'd0, ad1}, {20'd0, e_addr});
        chk("csr_addr0", {20'd0, ad0}, {20'd0, e_addr});
        if (e_wen) begin
            chk("csr_wdata1", wd1, e_wdata);
            chk("csr_wdata0", wd0, e_wdata);
        end
        chk("pl_rdata1", plr1, model_csr[e_addr]);
        chk("pl_rdata0", plr0, model_csr[e_addr]);
        chk("redirect_valid1", {31'd0, rv1}, {31'd0, m_rv});
        chk("redirect_valid0", {31'd0, rv0}, {31'd0, m_rv});
        chk("redirect_pc1", rpc1, m_rpc);
        chk("redirect_pc0", rpc0, m_rpc0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        pl_addr = a; pl_wdata = d; pl_wen = 1'b1;
        step();
        pl_wen = 1'b0;
    endtask

    task automatic do_trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] t);
        trap_valid = 1'b1; trap_cause = c; trap_epc = e; trap_tval = t;
        step();
        trap_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 32'd0; mem0[i] = 32'd0; model_csr[i] = 32'd0;
        end
        rst_n = 1'b1;
        trap_valid = 1'b0; mret_valid = 1'b0;
        trap_cause = 32'd0; trap_epc = 32'd0; trap_tval = 32'd0;
        pl_addr = 12'd0; pl_wdata = 32'd0; pl_wen = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset busy", {31'd0, busy1}, 32'd0);
        chk("reset redirect_valid", {31'd0, rv1}, 32'd0);
        chk("reset redirect_pc", rpc1, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Passthrough
        pl_addr = 12'h340; pl_wdata = 32'hDEADBEEF; pl_wen = 1'b1;
        #2;
        chk("pass csr_addr", {20'd0, ad1}, 32'h340);
        chk("pass csr_wen", {31'd0, wen1}, 32'd1);
        step();
        pl_wen = 1'b0;
        #2;
        chk("pass pl_rdata", plr1, 32'hDEADBEEF);

        // Exception
        wr_csr(12'h300, 32'h8);
        wr_csr(12'h305, 32'h1000);
        do_trap(32'd2, 32'h204, 32'h13);
        repeat (5) step();
        chk("exc redirect_valid", {31'd0, rv1}, 32'd1);
        chk("exc redirect_pc", rpc1, 32'h1000);
        chk("exc mepc", mem1[12'h341], 32'h204);
        chk("exc mcause", mem1[12'h342], 32'd2);
        chk("exc mtval", mem1[12'h343], 32'h13);
        chk("exc mstatus", mem1[12'h300], 32'h1880);

        // Vectored interrupt
        wr_csr(12'h305, 32'h1001);
        do_trap(32'h8000000B, 32'h300, 32'h0);
        repeat (5) step();
        chk("vec redirect_pc", rpc1, 32'h102C);
        chk("vec redirect_pc novec", rpc0, 32'h1000);

        // mret
        wr_csr(12'h300, 32'h1880);
        wr_csr(12'h341, 32'h208);
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        repeat (2) step();
        chk("mret redirect_valid", {31'd0, rv1}, 32'd1);
        chk("mret redirect_pc", rpc1, 32'h208);
        chk("mret mstatus", mem1[12'h300], 32'h1888);

        // Collision: trap + mret + pipeline write together, mret mid-trap,
        // then a new mret accepted in the redirect cycle.
        pl_addr = 12'h340; pl_wdata = 32'h55; pl_wen = 1'b1; mret_valid = 1'b1;
        do_trap(32'd5, 32'h3, 32'h77);
        pl_wen = 1'b0; mret_valid = 1'b0;
        step();
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        repeat (3) step();
        chk("coll redirect_pc", rpc1, 32'h1000);
        chk("coll no pl write", mem1[12'h340], 32'hDEADBEEF);
        chk("coll mepc aligned", mem1[12'h341], 32'h0);
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        repeat (2) step();
        chk("b2b mret redirect_pc", rpc1, 32'h0);
        chk("b2b mstatus", mem1[12'h300], 32'h1888);

        // Reset in T_TVAL
        do_trap(32'd7, 32'h400, 32'hABCD);
        repeat (2) step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy1}, 32'd0);
        chk("rst redirect_valid", {31'd0, rv1}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst mstatus kept", mem1[12'h300], 32'h1888);
        chk("rst mtval not written", mem1[12'h343], 32'h77);
        chk("rst mcause committed", mem1[12'h342], 32'd7);
        repeat (4) step();
        chk("rst no redirect", {31'd0, rv1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
